multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 29 ++
 rtl/multicycle_control_op_decode.sv | 76 +++++++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM and its datapath.
// Holds the FSM state, opcode and ALU-operation constants.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB_NE = 3'b001;
    localparam logic [2:0] ALU_RTYPE  = 3'b010;
    localparam logic [2:0] ALU_SUB_EQ = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b110;
    localparam logic [2:0] ALU_LUI    = 3'b111;

endpackage

// File: rtl/multicycle_control_op_decode.sv
// Combinational per-opcode decode: legality, instruction class, ALU op/src.
// Ports: op_i (opcode) in; legal_o, is_*_o class flags, alu_op_o, alu_src_o out.
module op_decode
    import multicycle_control_pkg::*;
#(
    parameter int ENABLE_LUI_ORI = 1
) (
    input  logic [5:0] op_i,
    output logic       legal_o,
    output logic       is_r_o,
    output logic       is_beq_o,
    output logic       is_bne_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic [2:0] alu_op_o,
    output logic       alu_src_o
);

    localparam logic LUI_ORI_OK = (ENABLE_LUI_ORI != 0);

    always_comb begin
        legal_o   = 1'b0;
        is_r_o    = 1'b0;
        is_beq_o  = 1'b0;
        is_bne_o  = 1'b0;
        is_lw_o   = 1'b0;
        is_sw_o   = 1'b0;
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b0;
        case (op_i)
            OP_R: begin
                legal_o  = 1'b1;
                is_r_o   = 1'b1;
                alu_op_o = ALU_RTYPE;
            end
            OP_BEQ: begin
                legal_o  = 1'b1;
                is_beq_o = 1'b1;
                alu_op_o = ALU_SUB_EQ;
            end
            OP_BNE: begin
                legal_o  = 1'b1;
                is_bne_o = 1'b1;
                alu_op_o = ALU_SUB_NE;
            end
            OP_ADDI: begin
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
            end
            OP_LUI: begin
                legal_o   = LUI_ORI_OK;
                alu_op_o  = ALU_LUI;
                alu_src_o = 1'b1;
            end
            OP_ORI: begin
                legal_o   = LUI_ORI_OK;
                alu_op_o  = ALU_OR;
                alu_src_o = 1'b1;
            end
            OP_LW: begin
                legal_o   = 1'b1;
                is_lw_o   = 1'b1;
                alu_src_o = 1'b1;
            end
            OP_SW: begin
                legal_o   = 1'b1;
                is_sw_o   = 1'b1;
                alu_src_o = 1'b1;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM (IF/ID/EX/MEM/WB) with retired-instruction counter.
// Ports: clk_i, rst_i (async, active-low), instr_op_i, zero_i, mem_ready_i in;
//        datapath strobes, alu_op_o, state_o, illegal_o, retired_o out.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_W       = 3,
    parameter int CNT_W          = 16,
    parameter int ENABLE_LUI_ORI = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                alu_src_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                mem_to_reg_o,
    output logic                pc_src_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [2:0]          state_o,
    output logic                illegal_o,
    output logic [CNT_W-1:0]    retired_o
);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [5:0] dec_op;
    logic       dec_legal;
    logic       dec_r;
    logic       dec_beq;
    logic       dec_bne;
    logic       dec_lw;
    logic       dec_sw;
    logic [2:0] dec_alu_op;
    logic       dec_alu_src;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic       retire;

    // In ID the opcode is not latched yet, so legality is judged on the
    // live IR field; later states decode the latched copy.
    assign dec_op = (state_q == ST_ID) ? instr_op_i : op_q;

    op_decode #(
        .ENABLE_LUI_ORI (ENABLE_LUI_ORI)
    ) u_op_decode (
        .op_i      (dec_op),
        .legal_o   (dec_legal),
        .is_r_o    (dec_r),
        .is_beq_o  (dec_beq),
        .is_bne_o  (dec_bne),
        .is_lw_o   (dec_lw),
        .is_sw_o   (dec_sw),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_read = 1'b1;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_ID;
                end
            end
            ST_ID: begin
                op_d = instr_op_i;
                if (dec_legal) begin
                    state_d = ST_EX;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_IF;
                end
            end
            ST_EX: begin
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                if (dec_beq || dec_bne) begin
                    pc_src   = 1'b1;
                    pc_write = (dec_beq & zero_i) | (dec_bne & ~zero_i);
                    retire   = 1'b1;
                    state_d  = ST_IF;
                end else if (dec_lw || dec_sw) begin
                    state_d = ST_MEM;
                end else if (dec_legal) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_MEM: begin
                mem_read  = dec_lw;
                mem_write = dec_sw;
                if (mem_ready_i) begin
                    if (dec_lw) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = dec_sw;
                        state_d = ST_IF;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = dec_r;
                mem_to_reg = dec_lw;
                retire     = 1'b1;
                state_d    = ST_IF;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    assign retired_d = retired_q + CNT_W'(retire);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IF;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // Gating with rst_i makes an in-flight access drop the moment reset
    // asserts, rather than at the next clock edge.
    assign pc_write_o   = pc_write & rst_i;
    assign ir_write_o   = ir_write & rst_i;
    assign reg_write_o  = reg_write & rst_i;
    assign reg_dst_o    = reg_dst & rst_i;
    assign alu_src_o    = alu_src & rst_i;
    assign mem_read_o   = mem_read & rst_i;
    assign mem_write_o  = mem_write & rst_i;
    assign mem_to_reg_o = mem_to_reg & rst_i;
    assign pc_src_o     = pc_src & rst_i;
    assign illegal_o    = illegal & rst_i;
    assign alu_op_o     = rst_i ? ALU_OP_W'(alu_op) : '0;
    assign state_o      = state_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: sequencing, strobes, reset, wrap.
// Second instance uses CNT_W=2 and lui/ori disabled.
module tb_multicycle_control;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic       pc_write, ir_write, reg_write, reg_dst, alu_src;
    logic       mem_read, mem_write, mem_to_reg, pc_src, illegal;
    logic [2:0] alu_op, state;
    logic [15:0] retired;

    logic       pc_write2, ir_write2, reg_write2, reg_dst2, alu_src2;
    logic       mem_read2, mem_write2, mem_to_reg2, pc_src2, illegal2;
    logic [2:0] alu_op2, state2;
    logic [1:0] retired2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    multicycle_control dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_op_i   (instr_op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write),
        .ir_write_o   (ir_write),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .alu_src_o    (alu_src),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_to_reg_o (mem_to_reg),
        .pc_src_o     (pc_src),
        .alu_op_o     (alu_op),
        .state_o      (state),
        .illegal_o    (illegal),
        .retired_o    (retired)
    );

    multicycle_control #(
        .CNT_W          (2),
        .ENABLE_LUI_ORI (0)
    ) dut2 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_op_i   (instr_op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write2),
        .ir_write_o   (ir_write2),
        .reg_write_o  (reg_write2),
        .reg_dst_o    (reg_dst2),
        .alu_src_o    (alu_src2),
        .mem_read_o   (mem_read2),
        .mem_write_o  (mem_write2),
        .mem_to_reg_o (mem_to_reg2),
        .pc_src_o     (pc_src2),
        .alu_op_o     (alu_op2),
        .state_o      (state2),
        .illegal_o    (illegal2),
        .retired_o    (retired2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk_no_writes(input string tag);
        chk({tag, ".wr"},
            32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b0;
        instr_op_i  = 6'b000000;
        zero_i      = 1'b0;
        mem_ready_i = 1'b1;
        #12;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.mem_read", 32'(mem_read), 32'd0);
        chk("rst.ir_write", 32'(ir_write), 32'd0);
        chk("rst.retired", 32'(retired), 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);

        // R-type, zero wait
        rst_i = 1'b1;
        #1;
        chk("r.if.strobes",
            32'({mem_read, ir_write, pc_write, pc_src}), 32'b1110);
        step();
        chk("r.id.state", 32'(state), 32'd1);
        chk_no_writes("r.id");
        chk("r.id.illegal", 32'(illegal), 32'd0);
        step();
        chk("r.ex.state", 32'(state), 32'd2);
        chk("r.ex.alu", 32'({alu_op, alu_src}), 32'b0100);
        step();
        chk("r.wb.state", 32'(state), 32'd4);
        chk("r.wb.strobes",
            32'({reg_write, reg_dst, mem_to_reg}), 32'b110);
        chk("r.wb.retired", 32'(retired), 32'd0);
        step();
        chk("r.done.state", 32'(state), 32'd0);
        chk("r.done.retired", 32'(retired), 32'd1);

        // lw with two wait cycles in MEM
        instr_op_i = 6'b100011;
        step();
        chk("lw.id.state", 32'(state), 32'd1);
        step();
        chk("lw.ex.alu", 32'({alu_op, alu_src}), 32'b0001);
        step();
        mem_ready_i = 1'b0;
        #1;
        chk("lw.mem1", 32'({state, mem_read, mem_write}), 32'b01110);
        step();
        chk("lw.mem2", 32'({state, mem_read, mem_write}), 32'b01110);
        step();
        mem_ready_i = 1'b1;
        #1;
        chk("lw.mem3", 32'({state, mem_read, mem_write}), 32'b01110);
        step();
        chk("lw.wb.state", 32'(state), 32'd4);
        chk("lw.wb.strobes",
            32'({reg_write, reg_dst, mem_to_reg}), 32'b101);
        step();
        chk("lw.done", 32'({state, retired[3:0]}), 32'b000_0010);

        // beq taken
        instr_op_i = 6'b000100;
        zero_i     = 1'b1;
        step();
        step();
        chk("beq.ex.state", 32'(state), 32'd2);
        chk("beq.ex.pc", 32'({pc_write, pc_src}), 32'b11);
        chk("beq.ex.alu", 32'(alu_op), 32'd3);
        step();
        chk("beq.done", 32'({state, retired[3:0]}), 32'b000_0011);
        chk("wrap.pre", 32'(retired2), 32'd3);

        // bne not taken
        instr_op_i = 6'b000101;
        step();
        step();
        chk("bne.ex.pc", 32'({pc_write, pc_src}), 32'b01);
        chk("bne.ex.alu", 32'(alu_op), 32'd1);
        step();
        chk("bne.done", 32'({state, retired[3:0]}), 32'b000_0100);
        chk("wrap.post", 32'(retired2), 32'd0);

        // unsupported opcode
        instr_op_i = 6'b111111;
        zero_i     = 1'b0;
        step();
        chk("ill.id.state", 32'(state), 32'd1);
        chk("ill.id.pulse", 32'(illegal), 32'd1);
        chk_no_writes("ill.id");
        chk("ill.id.rw", 32'({mem_read, reg_dst, mem_to_reg}), 32'd0);
        step();
        chk("ill.next", 32'({state, illegal}), 32'd0);
        chk("ill.retired", 32'(retired), 32'd4);

        // lui: legal on dut, illegal on dut2
        instr_op_i = 6'b001111;
        step();
        chk("lui.id.illegal", 32'(illegal), 32'd0);
        chk("lui.dis.illegal", 32'(illegal2), 32'd1);
        chk("lui.dis.wr", 32'({pc_write2, ir_write2, reg_write2}), 32'd0);
        step();
        chk("lui.ex.alu", 32'({alu_op, alu_src}), 32'b1111);
        chk("lui.dis.next", 32'({state2, illegal2}), 32'd0);
        chk("lui.dis.retired", 32'(retired2), 32'd0);
        step();
        chk("lui.wb.state", 32'(state), 32'd4);
        step();
        chk("lui.done", 32'(retired), 32'd5);

        // ori
        instr_op_i = 6'b001101;
        step();
        step();
        chk("ori.ex.alu", 32'({alu_op, alu_src}), 32'b1101);
        step();
        step();
        chk("ori.done", 32'({state, retired[3:0]}), 32'b000_0110);

        // sw aborted by reset in MEM
        instr_op_i = 6'b101011;
        step();
        step();
        chk("sw.ex.alu", 32'({alu_op, alu_src}), 32'b0001);
        step();
        mem_ready_i = 1'b0;
        #1;
        chk("sw.mem", 32'({state, mem_read, mem_write}), 32'b01101);
        rst_i = 1'b0;
        #1;
        chk("sw.rst.mw", 32'(mem_write), 32'd0);
        chk("sw.rst.state", 32'(state), 32'd0);
        chk("sw.rst.retired", 32'(retired), 32'd0);
        step();
        chk("sw.rst.hold", 32'({state, mem_read, pc_write}), 32'd0);
        mem_ready_i = 1'b1;
        instr_op_i  = 6'b000000;
        rst_i       = 1'b1;
        #1;
        chk("rel.if", 32'({state, mem_read, ir_write}), 32'b00011);
        step();
        chk("rel.id", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
